// File: rtl/butterfly_pipe.sv
// butterfly_pipe
//   Pipelined multi-lane NTT/INTT butterfly for Kyber (q=3329) and
//   Dilithium (q=8380417). It supports Cooley-Tukey (forward) and
//   Gentleman-Sande (inverse) modes, and an optional GS halving step.
//   All lanes share one valid/ready handshake. A single global stall holds
//   every stage while the downstream side back-pressures. The mode bits
//   travel with each beat, so mixed beats can follow each other back-to-back.
//   Latency is MUL_STAGES+2 cycles.
//
// Ports
//   clk_i, rst_i          clock; synchronous active-high reset
//   valid_i / ready_o     input beat handshake
//   a_i, b_i              operands in [0,2q), lane k at [k*DATA_W +: DATA_W]
//   twiddle_i             twiddle in [0,q), lane k at [k*COEF_W +: COEF_W]
//   sel_red_i             1 = Kyber modulus, 0 = Dilithium modulus
//   sel_butterfly_i       0 = CT, 1 = GS
//   sel_half_i            GS only: multiply both results by 2^-1 mod q
//   valid_o / ready_i     output beat handshake
//   a_o, b_o              results in [0,q), lane k at [k*COEF_W +: COEF_W]
module butterfly_pipe #(
  parameter int NUM_LANES  = 2,
  parameter int MUL_STAGES = 2,
  parameter int DATA_W     = 24,
  parameter int COEF_W     = 23
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        valid_i,
  output logic                        ready_o,
  input  logic [NUM_LANES*DATA_W-1:0] a_i,
  input  logic [NUM_LANES*DATA_W-1:0] b_i,
  input  logic [NUM_LANES*COEF_W-1:0] twiddle_i,
  input  logic                        sel_red_i,
  input  logic                        sel_butterfly_i,
  input  logic                        sel_half_i,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic [NUM_LANES*COEF_W-1:0] a_o,
  output logic [NUM_LANES*COEF_W-1:0] b_o
);
  localparam int IW          = COEF_W + 2;  // headroom for x+q and 2q-1 inputs
  localparam int PW          = 2 * COEF_W;
  localparam int Q_KYBER     = 3329;
  localparam int Q_DILITHIUM = 8380417;
  localparam int LAST        = MUL_STAGES - 1;

  typedef logic [COEF_W-1:0] coef_t;
  typedef logic [IW-1:0]     wide_t;
  typedef logic [PW-1:0]     prod_t;

  function automatic coef_t modulus(input logic kyber);
    return kyber ? coef_t'(Q_KYBER) : coef_t'(Q_DILITHIUM);
  endfunction

  function automatic coef_t reduce_in(input logic [DATA_W-1:0] x, input coef_t q);
    wide_t xe;
    xe = wide_t'(x);
    return (xe >= wide_t'(q)) ? coef_t'(xe - wide_t'(q)) : coef_t'(xe);
  endfunction

  function automatic coef_t mod_add(input coef_t x, input coef_t y, input coef_t q);
    wide_t s;
    s = wide_t'(x) + wide_t'(y);
    return (s >= wide_t'(q)) ? coef_t'(s - wide_t'(q)) : coef_t'(s);
  endfunction

  function automatic coef_t mod_sub(input coef_t x, input coef_t y, input coef_t q);
    return (x >= y) ? coef_t'(x - y) : coef_t'(wide_t'(x) + wide_t'(q) - wide_t'(y));
  endfunction

  // x * 2^-1 mod q: odd values become even by adding q (q is odd).
  function automatic coef_t mod_half(input coef_t x, input coef_t q);
    return x[0] ? coef_t'((wide_t'(x) + wide_t'(q)) >> 1) : coef_t'(x >> 1);
  endfunction

  // Constant divisors on each branch keep each reduction a fixed-modulus circuit.
  function automatic coef_t mul_red(input prod_t p, input logic kyber);
    return kyber ? coef_t'(p % prod_t'(Q_KYBER)) : coef_t'(p % prod_t'(Q_DILITHIUM));
  endfunction

  logic advance;

  // Stage 1: reduced operands; for GS, the pre-add and pre-subtract are already applied
  logic  s1_vld, s1_kyber, s1_gs, s1_half;
  coef_t s1_x [NUM_LANES];
  coef_t s1_m [NUM_LANES];
  coef_t s1_w [NUM_LANES];

  // Multiply stages: raw product registered first, then delayed
  logic [MUL_STAGES-1:0] mp_vld, mp_kyber, mp_gs, mp_half;
  prod_t mp_p [MUL_STAGES][NUM_LANES];
  coef_t mp_x [MUL_STAGES][NUM_LANES];

  coef_t q_in, q_out;
  coef_t a_red [NUM_LANES];
  coef_t b_red [NUM_LANES];
  coef_t t_out [NUM_LANES];
  coef_t a_nx  [NUM_LANES];
  coef_t b_nx  [NUM_LANES];

  assign advance = !valid_o || ready_i;
  assign ready_o = advance && !rst_i;

  always_comb begin
    q_in = modulus(sel_red_i);
    for (int k = 0; k < NUM_LANES; k++) begin
      a_red[k] = reduce_in(a_i[k*DATA_W +: DATA_W], q_in);
      b_red[k] = reduce_in(b_i[k*DATA_W +: DATA_W], q_in);
    end
  end

  always_comb begin
    q_out = modulus(mp_kyber[LAST]);
    for (int k = 0; k < NUM_LANES; k++) begin
      t_out[k] = mul_red(mp_p[LAST][k], mp_kyber[LAST]);
      a_nx[k]  = mod_add(mp_x[LAST][k], t_out[k], q_out);
      b_nx[k]  = mod_sub(mp_x[LAST][k], t_out[k], q_out);
      if (mp_gs[LAST]) begin
        a_nx[k] = mp_x[LAST][k];
        b_nx[k] = t_out[k];
        if (mp_half[LAST]) begin
          a_nx[k] = mod_half(mp_x[LAST][k], q_out);
          b_nx[k] = mod_half(t_out[k], q_out);
        end
      end
    end
  end

  // Valid bits and outputs
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_vld  <= 1'b0;
      mp_vld  <= '0;
      valid_o <= 1'b0;
      a_o     <= '0;
      b_o     <= '0;
    end else if (advance) begin
      s1_vld    <= valid_i;
      mp_vld[0] <= s1_vld;
      for (int i = 1; i < MUL_STAGES; i++) mp_vld[i] <= mp_vld[i-1];
      valid_o   <= mp_vld[LAST];
      for (int k = 0; k < NUM_LANES; k++) begin
        a_o[k*COEF_W +: COEF_W] <= a_nx[k];
        b_o[k*COEF_W +: COEF_W] <= b_nx[k];
      end
    end
  end

  // Datapath registers without reset
  always_ff @(posedge clk_i) begin
    if (advance) begin
      s1_kyber    <= sel_red_i;
      s1_gs       <= sel_butterfly_i;
      s1_half     <= sel_half_i;
      mp_kyber[0] <= s1_kyber;
      mp_gs[0]    <= s1_gs;
      mp_half[0]  <= s1_half;
      for (int k = 0; k < NUM_LANES; k++) begin
        s1_x[k]    <= sel_butterfly_i ? mod_add(a_red[k], b_red[k], q_in) : a_red[k];
        s1_m[k]    <= sel_butterfly_i ? mod_sub(a_red[k], b_red[k], q_in) : b_red[k];
        s1_w[k]    <= twiddle_i[k*COEF_W +: COEF_W];
        mp_p[0][k] <= prod_t'(s1_m[k]) * prod_t'(s1_w[k]);
        mp_x[0][k] <= s1_x[k];
      end
      for (int i = 1; i < MUL_STAGES; i++) begin
        mp_kyber[i] <= mp_kyber[i-1];
        mp_gs[i]    <= mp_gs[i-1];
        mp_half[i]  <= mp_half[i-1];
        for (int k = 0; k < NUM_LANES; k++) begin
          mp_p[i][k] <= mp_p[i-1][k];
          mp_x[i][k] <= mp_x[i-1][k];
        end
      end
    end
  end

endmodule
